// File: rtl/csr_trap.sv
// rtl/csr_trap.sv - machine-mode CSR file with trap entry/mret state and cycle/instret counters
module csr_trap #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap,
    input  logic [4:0]  trap_src,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        mret,
    input  logic        instret,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic [31:0] mtvec_rdata,
    output logic [31:0] mepc_rdata,
    output logic        mie
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic        csr_hit;
    logic [31:0] csr_old;
    logic [31:0] csr_new;
    logic        csr_wen;
    logic        instret_inc;

    // MPP is hardwired to machine mode, so mstatus always reads 0x1800 plus MIE/MPIE.
    always_comb begin
        csr_hit = 1'b1;
        csr_old = 32'h0;
        unique case (csr_addr)
            ADDR_MSTATUS:   csr_old = {19'h0, 2'b11, 3'b000, mpie_q, 3'b000, mie_q, 3'b000};
            ADDR_MTVEC:     csr_old = mtvec_q;
            ADDR_MSCRATCH:  csr_old = mscratch_q;
            ADDR_MEPC:      csr_old = mepc_q;
            ADDR_MCAUSE:    csr_old = mcause_q;
            ADDR_MTVAL:     csr_old = mtval_q;
            ADDR_MCYCLE:    csr_old = mcycle_q[31:0];
            ADDR_MCYCLEH:   csr_old = mcycle_q[63:32];
            ADDR_MINSTRET:  csr_old = minstret_q[31:0];
            ADDR_MINSTRETH: csr_old = minstret_q[63:32];
            default:        csr_hit = 1'b0;
        endcase
    end

    always_comb begin
        csr_new = csr_old & ~csr_wdata;
        if (csr_op == OP_WRITE) begin
            csr_new = csr_wdata;
        end else if (csr_op == OP_SET) begin
            csr_new = csr_old | csr_wdata;
        end
    end

    assign csr_illegal = (csr_op != OP_NONE) && !csr_hit;
    assign csr_wen     = (csr_op != OP_NONE) && csr_hit && !trap;
    assign instret_inc = instret && !trap;

    assign csr_rdata   = csr_old;
    assign mtvec_rdata = mtvec_q;
    assign mepc_rdata  = mepc_q;
    assign mie         = mie_q;

    // Writing one counter half replaces that half's increment; the written low half never carries.
    always_comb begin
        mcycle_d = mcycle_q + 64'd1;
        if (csr_wen && csr_addr == ADDR_MCYCLE) begin
            mcycle_d = {mcycle_q[63:32], csr_new};
        end else if (csr_wen && csr_addr == ADDR_MCYCLEH) begin
            mcycle_d = {csr_new, mcycle_q[31:0] + 32'd1};
        end

        minstret_d = minstret_q + {63'h0, instret_inc};
        if (csr_wen && csr_addr == ADDR_MINSTRET) begin
            minstret_d = {minstret_q[63:32], csr_new};
        end else if (csr_wen && csr_addr == ADDR_MINSTRETH) begin
            minstret_d = {csr_new, minstret_q[31:0] + {31'h0, instret_inc}};
        end
    end

    // Later assignments win: csr write < mret (mstatus only) < trap.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;

        if (csr_wen) begin
            unique case (csr_addr)
                ADDR_MSTATUS: begin
                    mie_d  = csr_new[3];
                    mpie_d = csr_new[7];
                end
                ADDR_MTVEC:    mtvec_d    = csr_new & ALIGN_MASK;
                ADDR_MSCRATCH: mscratch_d = csr_new;
                ADDR_MEPC:     mepc_d     = csr_new & ALIGN_MASK;
                ADDR_MCAUSE:   mcause_d   = csr_new;
                ADDR_MTVAL:    mtval_d    = csr_new;
                default: ;
            endcase
        end

        if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end

        if (trap) begin
            mepc_d   = trap_pc & ALIGN_MASK;
            mcause_d = {27'h0, trap_src};
            mtval_d  = trap_val;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= RESET_MTVEC & ALIGN_MASK;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mtval_q    <= 32'h0;
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule

// File: tb/tb_csr_trap.sv
// tb/tb_csr_trap.sv - scoreboard bench for csr_trap against a behavioural CSR model
module tb_csr_trap;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap;
    logic [4:0]  trap_src;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        mret;
    logic        instret;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] mtvec_rdata;
    logic [31:0] mepc_rdata;
    logic        mie;

    always #5 clk = ~clk;

    csr_trap #(.RESET_MTVEC(32'h0000_0103)) dut (
        .clk(clk), .rst(rst), .trap(trap), .trap_src(trap_src), .trap_pc(trap_pc),
        .trap_val(trap_val), .mret(mret), .instret(instret), .csr_op(csr_op),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal), .mtvec_rdata(mtvec_rdata), .mepc_rdata(mepc_rdata),
        .mie(mie)
    );

    typedef struct {
        logic [11:0] addr;
        bit          chk_rd;
        logic [31:0] rd;
        logic        ill;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        m_ie;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    bit        m_mie, m_mpie;
    bit [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    bit [63:0] m_cyc, m_ins;

    localparam bit [63:0] HI_MASK = 64'hFFFF_FFFF_0000_0000;
    localparam bit [63:0] LO_MASK = 64'h0000_0000_FFFF_FFFF;

    function automatic bit m_impl(input logic [11:0] a);
        return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                         12'hB00, 12'hB80, 12'hB02, 12'hB82};
    endfunction

    function automatic bit [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hB00: return 32'(m_cyc);
            12'hB80: return 32'(m_cyc >> 32);
            12'hB02: return 32'(m_ins);
            12'hB82: return 32'(m_ins >> 32);
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_reset();
        m_mie = 0; m_mpie = 0; m_mtvec = 32'h100;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cyc = 0; m_ins = 0;
    endfunction

    function automatic void m_update();
        bit        wen;
        bit [31:0] oldv, nv;
        bit        old_mie, old_mpie;
        bit [63:0] step_ins;
        if (rst) begin
            m_reset();
            return;
        end
        old_mie  = m_mie;
        old_mpie = m_mpie;
        wen  = (csr_op != 2'b00) && m_impl(csr_addr) && !trap;
        oldv = m_read(csr_addr);
        nv   = (csr_op == 2'b01) ? csr_wdata :
               (csr_op == 2'b10) ? (oldv | csr_wdata) : (oldv & ~csr_wdata);
        step_ins = (instret && !trap) ? 64'd1 : 64'd0;

        if (wen && csr_addr == 12'hB00)      m_cyc = (m_cyc & HI_MASK) | 64'(nv);
        else if (wen && csr_addr == 12'hB80) m_cyc = (64'(nv) << 32) | ((m_cyc + 1) & LO_MASK);
        else                                 m_cyc = m_cyc + 1;

        if (wen && csr_addr == 12'hB02)      m_ins = (m_ins & HI_MASK) | 64'(nv);
        else if (wen && csr_addr == 12'hB82) m_ins = (64'(nv) << 32) | ((m_ins + step_ins) & LO_MASK);
        else                                 m_ins = m_ins + step_ins;

        if (wen) begin
            case (csr_addr)
                12'h300: if (!mret) begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h305: m_mtvec = nv & 32'hFFFF_FFFC;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & 32'hFFFF_FFFC;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                default: ;
            endcase
        end
        if (trap) begin
            m_mepc   = trap_pc & 32'hFFFF_FFFC;
            m_mcause = 32'(trap_src);
            m_mtval  = trap_val;
            m_mpie   = old_mie;
            m_mie    = 0;
        end else if (mret) begin
            m_mie  = old_mpie;
            m_mpie = 1;
        end
    endfunction

    task automatic idle();
        rst = 0; trap = 0; trap_src = 0; trap_pc = 0; trap_val = 0;
        mret = 0; instret = 0; csr_op = 2'b00; csr_addr = 12'h300; csr_wdata = 0;
    endtask

    // Inputs are already set; record this cycle's expected outputs, advance the model, wait one clock.
    task automatic step();
        exp_t e;
        e.addr   = csr_addr;
        e.chk_rd = m_impl(csr_addr);
        e.rd     = m_read(csr_addr);
        e.ill    = (csr_op != 2'b00) && !m_impl(csr_addr);
        e.mtvec  = m_mtvec;
        e.mepc   = m_mepc;
        e.m_ie   = m_mie;
        sb.push_back(e);
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        idle(); csr_addr = a; step();
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        idle(); csr_op = op; csr_addr = a; csr_wdata = d; step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (e.chk_rd) chk($sformatf("csr_rdata@%h", e.addr), csr_rdata, e.rd);
                chk("csr_illegal", 32'(csr_illegal), 32'(e.ill));
                chk("mtvec_rdata", mtvec_rdata, e.mtvec);
                chk("mepc_rdata", mepc_rdata, e.mepc);
                chk("mie", 32'(mie), 32'(e.m_ie));
            end
        end
    end

    initial begin
        logic [11:0] addrs [12];
        addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                  12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0, 12'h301};
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        m_reset();

        rd(12'h300);
        wr(2'b10, 12'h300, 32'h8);
        idle(); trap = 1; trap_src = 5'd11; trap_pc = 32'h84; trap_val = 0; step();
        rd(12'h342);
        rd(12'h341);
        idle(); mret = 1; step();
        rd(12'h300);

        wr(2'b01, 12'hB80, 32'h0);
        wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00);
        rd(12'hB80);
        wr(2'b01, 12'hB00, 32'h5);
        rd(12'hB00);

        wr(2'b01, 12'h340, 32'h1234);
        rd(12'hB02);
        idle(); trap = 1; trap_src = 5'd2; trap_pc = 32'h1003; trap_val = 32'hBAD;
        instret = 1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'hDEAD; step();
        rd(12'h340);
        rd(12'hB02);
        rd(12'h343);
        wr(2'b01, 12'h7C0, 32'hFFFF_FFFF);
        rd(12'h300);

        idle(); rst = 1; trap = 1; trap_src = 5'd7; trap_pc = 32'h200; step();
        rd(12'h342);
        rd(12'hB00);

        for (int i = 0; i < 3000; i++) begin
            idle();
            rst      = ($urandom_range(0, 99) == 0);
            trap     = ($urandom_range(0, 7) == 0);
            trap_src = 5'($urandom);
            trap_pc  = $urandom;
            trap_val = $urandom;
            instret  = 1'($urandom);
            csr_addr = addrs[$urandom_range(0, 11)];
            csr_wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            if ($urandom_range(0, 7) == 0) mret = 1;
            else csr_op = 2'($urandom);
            step();
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
